wptr_full: RTL
==============

# wptr_full

Write-side pointer manager for the asynchronous FIFO, and the source end of the write-to-read pointer crossing. It keeps the binary write pointer and generates the RAM write address. It also drives a registered Gray-coded write pointer for the two-flop pointer synchronizer in the read domain. Full, almost-full, fill level and write handshake flags come from the read pointer, which arrives already synchronized into the write domain.

## Interface

Parameters:
- WIDTH_D, 5, address width. Pointers are WIDTH_D+1 bits wide, with the MSB as the wrap bit. Depth = 2^WIDTH_D (32).
- AF_LEVEL, 28, fill level at or above which wr_almost_full is asserted. Range 1..2^WIDTH_D.

Ports:
- wr_clk, in, 1, write-domain clock. This is the only clock; all state updates on its rising edge.
- wr_rst, in, 1, reset. Synchronous, active-high.
- wr_en, in, 1, write request.
- rptr_syn, in, WIDTH_D+1, Gray-coded read pointer, already synchronized into wr_clk.
- wr_addr, out, WIDTH_D, RAM write address, equal to wbin[WIDTH_D-1:0].
- wr_ptr_gray, out, WIDTH_D+1, registered Gray write pointer. Feeds the read-domain synchronizer.
- wr_full, out, 1, registered full flag.
- wr_almost_full, out, 1, registered, asserted when level >= AF_LEVEL.
- wr_level, out, WIDTH_D+1, registered fill level, range 0..2^WIDTH_D.
- wr_ack, out, 1, one-cycle pulse after an accepted write.
- wr_overflow, out, 1, one-cycle pulse after a write rejected because the FIFO was full.

## Operation

- push = wr_en & ~wr_full. The RAM write enable is this same push term, taken at wr_addr in the same cycle.
- Next binary pointer: wbin_next = wbin + push, modulo 2^(WIDTH_D+1). The pointer wraps naturally.
- Next Gray pointer: wgray_next = wbin_next ^ (wbin_next >> 1).
- Read pointer: rbin = Gray-to-binary of rptr_syn (prefix XOR from the MSB down).
- Full condition: full_next = (wgray_next == {~rptr_syn[WIDTH_D:WIDTH_D-1], rptr_syn[WIDTH_D-2:0]}).
- Level: level_next = (wbin_next - rbin) mod 2^(WIDTH_D+1).
- Almost-full: af_next = (level_next >= AF_LEVEL).
- Registered every cycle: wbin <= wbin_next, wr_ptr_gray <= wgray_next, wr_full <= full_next, wr_level <= level_next, wr_almost_full <= af_next.
- wr_ack <= push. wr_overflow <= wr_en & wr_full.
- wr_ptr_gray comes straight from a flop, with no combinational logic after it. Between consecutive cycles it changes in at most one bit. It never changes when push was 0.
- Reset (wr_rst = 1 at an edge): wbin, wr_ptr_gray, wr_level, wr_full, wr_almost_full, wr_ack and wr_overflow all go to 0. wr_addr = 0. Reset overrides wr_en in the same cycle.
- Reset mid-operation has no memory of the old pointer. The read side must be reset together with this block. That is a system rule, not something this block checks.
- Flags are pessimistic, because rptr_syn lags the real read pointer by the synchronizer latency:
  - wr_full may stay asserted after the read side has freed space.
  - wr_full never deasserts while the FIFO is actually full.
- wr_en while full is ignored: the pointer does not move and wr_overflow pulses.

## Timing

- The write accepted at edge N uses wr_addr as it was before edge N. After edge N: wr_addr increments, wr_ptr_gray updates, and wr_ack = 1 for one cycle.
- wr_full asserts at the same edge as the write that fills the FIFO. The next cycle's wr_en is therefore already blocked, so there is no extra latency.
- A change on rptr_syn is reflected in wr_full, wr_level and wr_almost_full one edge later.
- A write and an rptr_syn advance in the same cycle: both are accounted for in the same next-state values. The level stays unchanged.
- Wrap: after 2^(WIDTH_D+1) writes, wbin returns to 0 and wr_ptr_gray returns to 0. The MSB toggle between laps is what separates full from empty.

## Test plan

- Reset: hold wr_rst for 2 cycles with wr_en = 1 → all outputs 0, and no ack while in reset.
- Fill: rptr_syn = 0, 32 consecutive writes → wr_addr runs 0..31. After the 32nd edge: wr_full = 1, wr_level = 32, wr_ptr_gray = 6'b110000. wr_almost_full rises after the 28th write.
- Overflow: while full, wr_en = 1 for 3 cycles → wr_overflow = 1 for 3 cycles, wr_ack = 0, and wr_ptr_gray and wr_addr hold.
- Drain response: from full, step rptr_syn to gray(1) = 6'b000001 → one edge later wr_full = 0 and wr_level = 31. The next write is accepted at wr_addr = 0, then wr_full = 1 again.
- Wrap and Gray check: track rptr_syn = gray(wbin - 4) and write continuously for 200 cycles → wr_ptr_gray changes in exactly one bit per accepted write and wraps 63→0. wr_level stays at 4, and wr_full never asserts.
- Reset mid-operation: at level 17, assert wr_rst together with wr_en → the next cycle shows all outputs 0. Normal writes resume from address 0.

Source files
------------

// File: rtl/wptr_full.sv
// -----------------------------------------------------------------------------
// wptr_full
//
// Write-side pointer manager for an asynchronous FIFO. It holds the binary
// write pointer, produces the RAM write address, and drives a registered Gray
// write pointer toward the read-domain synchronizer. Full, almost-full, fill
// level and the write handshake pulses are derived from the read pointer,
// which arrives Gray coded and already synchronized into wr_clk.
//
// Parameters
//   WIDTH_D        address width; pointers carry one extra wrap bit
//   AF_LEVEL       fill level at or above which wr_almost_full asserts
//
// Ports
//   wr_clk         write-domain clock (only clock)
//   wr_rst         synchronous active-high reset
//   wr_en          write request
//   rptr_syn       Gray read pointer, synchronized into wr_clk
//   wr_addr        RAM write address (low bits of the binary pointer)
//   wr_ptr_gray    registered Gray write pointer for the crossing
//   wr_full        registered full flag
//   wr_almost_full registered, level >= AF_LEVEL
//   wr_level       registered fill level, 0..2^WIDTH_D
//   wr_ack         one-cycle pulse after an accepted write
//   wr_overflow    one-cycle pulse after a write rejected while full
// -----------------------------------------------------------------------------
module wptr_full #(
  parameter int WIDTH_D  = 5,
  parameter int AF_LEVEL = 28
) (
  input  logic               wr_clk,
  input  logic               wr_rst,
  input  logic               wr_en,
  input  logic [WIDTH_D:0]   rptr_syn,
  output logic [WIDTH_D-1:0] wr_addr,
  output logic [WIDTH_D:0]   wr_ptr_gray,
  output logic               wr_full,
  output logic               wr_almost_full,
  output logic [WIDTH_D:0]   wr_level,
  output logic               wr_ack,
  output logic               wr_overflow
);

  localparam logic [WIDTH_D:0] AF_THR = (WIDTH_D+1)'(AF_LEVEL);

  logic [WIDTH_D:0] wbin;
  logic [WIDTH_D:0] wbin_next;
  logic [WIDTH_D:0] wgray_next;
  logic [WIDTH_D:0] rbin;
  logic [WIDTH_D:0] rgray_full;
  logic [WIDTH_D:0] level_next;
  logic             push;
  logic             full_next;
  logic             af_next;

  // The RAM is written with this same term at wr_addr during this cycle.
  assign push       = wr_en & ~wr_full;
  assign wbin_next  = wbin + {{WIDTH_D{1'b0}}, push};
  assign wgray_next = wbin_next ^ (wbin_next >> 1);

  // Gray to binary: each bit is the XOR of all Gray bits from the MSB down.
  always_comb begin
    rbin = '0;
    for (int i = 0; i <= WIDTH_D; i++) begin
      rbin[i] = ^(rptr_syn >> i);
    end
  end

  // Full when the write pointer is exactly one lap ahead of the read pointer.
  // In Gray code that is the read pointer with its two top bits inverted.
  assign rgray_full = {~rptr_syn[WIDTH_D:WIDTH_D-1], rptr_syn[WIDTH_D-2:0]};
  assign full_next  = (wgray_next == rgray_full);
  assign level_next = wbin_next - rbin;
  assign af_next    = (level_next >= AF_THR);

  assign wr_addr = wbin[WIDTH_D-1:0];

  // NOTE: state flops use non-blocking assignments so every register samples
  // the pre-edge values; the reset branch is synchronous and wins over wr_en.
  always_ff @(posedge wr_clk) begin
    if (wr_rst) begin
      wbin           <= '0;
      wr_ptr_gray    <= '0;
      wr_full        <= 1'b0;
      wr_almost_full <= 1'b0;
      wr_level       <= '0;
      wr_ack         <= 1'b0;
      wr_overflow    <= 1'b0;
    end else begin
      wbin           <= wbin_next;
      wr_ptr_gray    <= wgray_next;
      wr_full        <= full_next;
      wr_almost_full <= af_next;
      wr_level       <= level_next;
      wr_ack         <= push;
      wr_overflow    <= wr_en & wr_full;
    end
  end

endmodule
